nibble_serial_sub_seq: RTL and testbench
========================================

// Module: nibble_serial_sub_seq
// PURPOSE
//  Sequencer that performs a wide unsigned subtraction A - B - Bin by feeding the registered 4-bit nibble
//  subtract stage one nibble per cycle, LSB nibble first. It chains the stage's borrow and assembles the
//  wide difference and final borrow. It sits directly upstream of the nibble stage and also consumes its outputs.
//  It uses a valid/ready handshake on both the operand side and the result side.
// PARAMETERS
//  NIBBLES  4  number of 4-bit nibbles per operand; WIDTH = 4*NIBBLES (localparam); legal range 1..16
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  start_valid in   1      operands valid
//  start_ready out  1      sequencer can accept operands (high only in IDLE)
//  op_a        in   WIDTH  minuend, [WIDTH-1:0], bit 0 = LSB
//  op_b        in   WIDTH  subtrahend, same ordering
//  borrow_in   in   1      initial borrow
//  nib_a       out  4      to stage minuend, [0:3], element 3 = LSB
//  nib_b       out  4      to stage subtrahend, [0:3], element 3 = LSB
//  nib_bin     out  1      to stage borrow-in
//  nib_diff    in   4      from stage difference, [0:3], element 3 = LSB; registered in stage, 1-cycle latency
//  nib_bout    in   1      from stage borrow-out; registered in stage
//  res_valid   out  1      result valid (high only in DONE)
//  res_ready   in   1      consumer takes result
//  result      out  WIDTH  A - B - Bin mod 2^WIDTH
//  borrow_out  out  1      1 when A < B + Bin (unsigned)
//  zero        out  1      1 when result == 0
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, idx=0, result=0, borrow_out=0, zero=0, res_valid=0, start_ready=1.
//   The stage has no reset, so its outputs are never used outside ISSUE with idx>0 or DRAIN.
//  IDLE: start_ready=1. On start_valid&start_ready: latch op_a, op_b, borrow_in; idx<=0; go to ISSUE.
//  ISSUE: drive nib_a/nib_b = latched nibble idx, with the bit order remapped to [0:3] (element 3 = operand bit 4*idx).
//   nib_bin = latched borrow_in if idx==0, else nib_bout (combinational pass-through of the stage's register).
//   If idx>0: result nibble idx-1 <= nib_diff.
//   If idx==NIBBLES-1: go to DRAIN; else idx<=idx+1.
//  DRAIN: result nibble NIBBLES-1 <= nib_diff; borrow_out <= nib_bout; zero <= (final result==0); go to DONE.
//  DONE: res_valid=1; result, borrow_out and zero are held stable. On res_ready: go to IDLE.
//   res_valid drops on the next cycle.
//  Outside ISSUE: nib_a=0, nib_b=0, nib_bin=0.
//  Latency: operands accepted at edge E0; res_valid high after edge E0+NIBBLES+1 (5 cycles for NIBBLES=4).
//  Throughput: one operation per NIBBLES+3 cycles at full res_ready. Operand accept and result release never share a cycle.
//  start_valid outside IDLE: ignored and not queued. op_a/op_b changing after accept: no effect.
//  Wrap-around: the result is modulo 2^WIDTH; borrow_out is the borrow out of the MSB nibble.
//  NIBBLES=1: ISSUE lasts one cycle, then DRAIN; latency 2.
// STRUCTURE
//  Package sub_seq_pkg: NIB_W=4; state typedef {IDLE, ISSUE, DRAIN, DONE} (2-bit encoding).
//  Single module holding the FSM, the idx counter ($clog2(NIBBLES), min 1 bit), the operand latches and
//   the result register. No sub-module.
//  The parent instantiates the nibble subtract stage beside this block. The bench uses a 1-cycle
//   registered nibble-subtract model.
// TESTING (NIBBLES=4 unless noted; bench = this block + registered nibble-stage model)
//  1. a=0x1234, b=0x0234, bin=0 -> result=0x1000, borrow_out=0, zero=0; res_valid exactly 5 cycles after accept.
//  2. a=0x0000, b=0x0001, bin=0 -> result=0xFFFF, borrow_out=1; the borrow ripples through all 4 nibbles.
//  3. a=0x8000, b=0x7FFF, bin=1 -> result=0x0000, borrow_out=0, zero=1.
//  4. Hold res_ready=0 for 3 cycles in DONE and pulse start_valid -> outputs stable, start_ready=0, no accept;
//     after res_ready=1, IDLE then the next operation is accepted and is correct.
//  5. Assert rst_n=0 while in ISSUE at idx=2 -> all outputs 0 immediately, start_ready=1 after release;
//     next a=0x00FF, b=0x0010 -> result 0x00EF.
//  6. NIBBLES=1: a=0x3, b=0x5, bin=0 -> result=0xE, borrow_out=1, res_valid 2 cycles after accept.

Source files
------------

// File: rtl/sub_seq_pkg.sv
// ---------------------------------------------------------------------------
// sub_seq_pkg
//   Shared definitions for the nibble-serial subtract sequencer.
//   NIB_W   : width of one operand nibble handed to the nibble stage.
//   state_t : sequencer FSM states, 2-bit encoding.
// ---------------------------------------------------------------------------
package sub_seq_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage : sub_seq_pkg

// File: rtl/nibble_serial_sub_seq.sv
// ---------------------------------------------------------------------------
// nibble_serial_sub_seq
//   Computes A - B - Bin over WIDTH = 4*NIBBLES bits by walking an external,
//   registered 4-bit subtract stage one nibble per cycle, LSB nibble first.
//   The stage's borrow is chained back into it. The wide difference, the
//   final borrow and a zero flag are then presented on a valid/ready port.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start_valid / start_ready   operand handshake (ready only in IDLE)
//   op_a, op_b, borrow_in       minuend, subtrahend, initial borrow
//   nib_a, nib_b, nib_bin       to the nibble stage ([0:3], element 3 = LSB)
//   nib_diff, nib_bout          from the nibble stage (registered, 1 cycle)
//   res_valid / res_ready       result handshake (valid only in DONE)
//   result, borrow_out, zero    difference mod 2^WIDTH, MSB borrow, result==0
// ---------------------------------------------------------------------------
module nibble_serial_sub_seq
   import sub_seq_pkg::*;
#(
   parameter  int NIBBLES = 4,
   localparam int WIDTH   = NIB_W * NIBBLES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_valid,
   output logic               start_ready,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic               borrow_in,
   output logic [0:NIB_W-1]   nib_a,
   output logic [0:NIB_W-1]   nib_b,
   output logic               nib_bin,
   input  logic [0:NIB_W-1]   nib_diff,
   input  logic               nib_bout,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [WIDTH-1:0]   result,
   output logic               borrow_out,
   output logic               zero
);

   localparam int                IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic               bin_q, bin_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               borrow_q, borrow_d;
   logic               zero_q, zero_d;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      bin_d    = bin_q;
      result_d = result_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;
      nib_a    = '0;
      nib_b    = '0;
      nib_bin  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_valid) begin
               op_a_d  = op_a;
               op_b_d  = op_b;
               bin_d   = borrow_in;
               idx_d   = '0;
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            // Assigning a [3:0] slice to a [0:3] port maps operand bit 4*idx
            // onto element 3, so the numeric nibble value is preserved.
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  nib_a = op_a_q[i*NIB_W +: NIB_W];
                  nib_b = op_b_q[i*NIB_W +: NIB_W];
               end
            end
            // The stage output is only meaningful once it has seen nibble 0.
            nib_bin = (idx_q == '0) ? bin_q : nib_bout;
            for (int i = 1; i < NIBBLES; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  result_d[(i-1)*NIB_W +: NIB_W] = nib_diff;
               end
            end
            if (idx_q == LAST_IDX) begin
               state_d = DRAIN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         DRAIN: begin
            // Last nibble leaves the stage this cycle; zero must see it too.
            result_d[WIDTH-NIB_W +: NIB_W] = nib_diff;
            borrow_d = nib_bout;
            zero_d   = (result_d == '0);
            state_d  = DONE;
         end

         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         result_q <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
      end
   end

   // Operand latches carry data only; they are always reloaded before use.
   always_ff @(posedge clk) begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      bin_q  <= bin_d;
   end

   assign start_ready = (state_q == IDLE);
   assign res_valid   = (state_q == DONE);
   assign result      = result_q;
   assign borrow_out  = borrow_q;
   assign zero        = zero_q;

endmodule : nibble_serial_sub_seq

// File: tb/tb_nibble_serial_sub_seq.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_sub_seq
//   Bench for the nibble-serial subtract sequencer: a NIBBLES=4 instance and
//   a NIBBLES=1 instance, each paired with a registered nibble-subtract model,
//   checked against a plain-arithmetic reference of A - B - Bin.
// ---------------------------------------------------------------------------
module tb_nibble_serial_sub_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- NIBBLES = 4 instance ----------------
   logic        start_valid = 1'b0, start_ready;
   logic [15:0] op_a = '0, op_b = '0;
   logic        borrow_in = 1'b0;
   logic [0:3]  nib_a, nib_b, nib_diff;
   logic        nib_bin, nib_bout;
   logic        res_valid, res_ready = 1'b0;
   logic [15:0] result;
   logic        borrow_out, zero;

   nibble_serial_sub_seq #(.NIBBLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .op_a(op_a), .op_b(op_b), .borrow_in(borrow_in),
      .nib_a(nib_a), .nib_b(nib_b), .nib_bin(nib_bin),
      .nib_diff(nib_diff), .nib_bout(nib_bout),
      .res_valid(res_valid), .res_ready(res_ready),
      .result(result), .borrow_out(borrow_out), .zero(zero)
   );

   // Registered nibble subtract stage (no reset).
   wire [4:0] stage4 = {1'b0, nib_a} - {1'b0, nib_b} - {4'd0, nib_bin};
   always @(posedge clk) {nib_bout, nib_diff} <= stage4;

   // ---------------- NIBBLES = 1 instance ----------------
   logic        start_valid1 = 1'b0, start_ready1;
   logic [3:0]  op_a1 = '0, op_b1 = '0;
   logic        borrow_in1 = 1'b0;
   logic [0:3]  nib_a1, nib_b1, nib_diff1;
   logic        nib_bin1, nib_bout1;
   logic        res_valid1, res_ready1 = 1'b0;
   logic [3:0]  result1;
   logic        borrow_out1, zero1;

   nibble_serial_sub_seq #(.NIBBLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid1), .start_ready(start_ready1),
      .op_a(op_a1), .op_b(op_b1), .borrow_in(borrow_in1),
      .nib_a(nib_a1), .nib_b(nib_b1), .nib_bin(nib_bin1),
      .nib_diff(nib_diff1), .nib_bout(nib_bout1),
      .res_valid(res_valid1), .res_ready(res_ready1),
      .result(result1), .borrow_out(borrow_out1), .zero(zero1)
   );

   wire [4:0] stage1 = {1'b0, nib_a1} - {1'b0, nib_b1} - {4'd0, nib_bin1};
   always @(posedge clk) {nib_bout1, nib_diff1} <= stage1;

   // Reference: {borrow, difference} of an unsigned wide subtraction.
   function automatic logic [16:0] ref_sub16(input logic [15:0] a, input logic [15:0] b,
                                             input logic bin);
      return {1'b0, a} - {1'b0, b} - {16'd0, bin};
   endfunction

   function automatic logic [4:0] ref_sub4(input logic [3:0] a, input logic [3:0] b,
                                           input logic bin);
      return {1'b0, a} - {1'b0, b} - {4'd0, bin};
   endfunction

   // Present operands, wait for accept and for res_valid. lat = edges from the
   // accept edge to the first cycle res_valid is seen (-1 on timeout).
   task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                 output logic [15:0] r, output logic bo, output logic z,
                                 output int lat);
      int n;
      op_a = a; op_b = b; borrow_in = bin; start_valid = 1'b1;
      n = 0;
      while (!start_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
      // Scramble inputs after accept; they must not affect the operation.
      op_a = 16'($urandom); op_b = 16'($urandom); borrow_in = 1'($urandom);
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!res_valid && lat < 40);
      if (!res_valid) lat = -1;
      r = result; bo = borrow_out; z = zero;
   endtask

   task automatic release_result(input int hold);
      repeat (hold) begin @(posedge clk); #1; end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         input int hold, output logic [15:0] r, output logic bo,
                         output logic z, output int lat);
      start_and_wait(a, b, bin, r, bo, z, lat);
      release_result(hold);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got=%b exp=1", start_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
      checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got=%h exp=0000", result); end
      checks++; if ({borrow_out, zero} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {borrow_out, zero}); end
      checks++; if ({nib_a, nib_b, nib_bin} !== 9'h0) begin errors++; $display("FAIL reset_nib got=%h exp=0", {nib_a, nib_b, nib_bin}); end
      checks++; if ({start_ready1, res_valid1, result1} !== 6'b100000) begin errors++; $display("FAIL reset_n1 got=%b exp=100000", {start_ready1, res_valid1, result1}); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [15:0] r; logic bo, z; int lat;
      run_op(16'h1234, 16'h0234, 1'b0, 0, r, bo, z, lat);
      checks++; if ({r, bo, z} !== {16'h1000, 1'b0, 1'b0}) begin errors++; $display("FAIL dir1_result got=%h/%b/%b exp=1000/0/0", r, bo, z); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL dir1_latency got=%0d exp=5", lat); end
      run_op(16'h0000, 16'h0001, 1'b0, 1, r, bo, z, lat);
      checks++; if ({r, bo, z} !== {16'hFFFF, 1'b1, 1'b0}) begin errors++; $display("FAIL dir2_ripple got=%h/%b/%b exp=ffff/1/0", r, bo, z); end
      run_op(16'h8000, 16'h7FFF, 1'b1, 0, r, bo, z, lat);
      checks++; if ({r, bo, z} !== {16'h0000, 1'b0, 1'b1}) begin errors++; $display("FAIL dir3_zero got=%h/%b/%b exp=0000/0/1", r, bo, z); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL dir3_latency got=%0d exp=5", lat); end
   endtask

   task automatic test_backpressure();
      logic [15:0] r; logic bo, z; int lat;
      logic [16:0] exp;
      exp = ref_sub16(16'h5A5A, 16'h6B6B, 1'b1);
      start_and_wait(16'h5A5A, 16'h6B6B, 1'b1, r, bo, z, lat);
      checks++; if ({r, bo} !== {exp[15:0], exp[16]}) begin errors++; $display("FAIL bp_result got=%h/%b exp=%h/%b", r, bo, exp[15:0], exp[16]); end
      for (int k = 0; k < 3; k++) begin
         start_valid = 1'b1; op_a = 16'($urandom); op_b = 16'($urandom);
         @(posedge clk); #1;
         checks++;
         if ({res_valid, start_ready, result, borrow_out, zero} !== {1'b1, 1'b0, exp[15:0], exp[16], exp[15:0] == 16'h0}) begin
            errors++;
            $display("FAIL bp_hold cycle=%0d got v=%b rdy=%b r=%h bo=%b exp v=1 rdy=0 r=%h bo=%b", k, res_valid, start_ready, result, borrow_out, exp[15:0], exp[16]);
         end
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      checks++; if ({res_valid, start_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", res_valid, start_ready); end
      @(posedge clk); #1;
      checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL bp_no_queue got rdy=%b exp=1", start_ready); end
      run_op(16'hC0DE, 16'h0ACE, 1'b0, 0, r, bo, z, lat);
      checks++; if ({r, bo, lat} !== {16'hB610, 1'b0, 32'd5}) begin errors++; $display("FAIL bp_next got=%h/%b lat=%0d exp=b610/0 lat=5", r, bo, lat); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] r; logic bo, z; int lat;
      op_a = 16'hFFFF; op_b = 16'h0000; borrow_in = 1'b0; start_valid = 1'b1;
      @(posedge clk); #1;               // accepted; ISSUE idx=0
      start_valid = 1'b0;
      @(posedge clk); #1;               // idx=1
      @(posedge clk); #1;               // idx=2, result nibble 0 written
      rst_n = 1'b0;
      #1;
      checks++;
      if ({result, borrow_out, zero, res_valid, nib_a, nib_b, nib_bin} !== 28'h0) begin
         errors++;
         $display("FAIL midrst_outputs got r=%h bo=%b z=%b v=%b na=%h nb=%h nbin=%b exp all 0", result, borrow_out, zero, res_valid, nib_a, nib_b, nib_bin);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", start_ready); end
      run_op(16'h00FF, 16'h0010, 1'b0, 0, r, bo, z, lat);
      checks++; if ({r, bo, z} !== {16'h00EF, 1'b0, 1'b0}) begin errors++; $display("FAIL midrst_next got=%h/%b/%b exp=00ef/0/0", r, bo, z); end
   endtask

   task automatic test_random();
      logic [15:0] r, a, b; logic bo, z, bin; int lat;
      logic [16:0] exp;
      for (int k = 0; k < 30; k++) begin
         a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
         if (k == 3) b = a;
         if (k == 4) begin b = a; bin = 1'b1; end
         exp = ref_sub16(a, b, bin);
         run_op(a, b, bin, int'($urandom_range(0, 2)), r, bo, z, lat);
         checks++;
         if ({r, bo, z, lat} !== {exp[15:0], exp[16], exp[15:0] == 16'h0, 32'd5}) begin
            errors++;
            $display("FAIL random k=%0d a=%h b=%h bin=%b got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=5", k, a, b, bin, r, bo, z, lat, exp[15:0], exp[16], exp[15:0] == 16'h0);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a, b; logic bin; logic [16:0] exp;
      int t, n, prev_acc;
      t = 0; prev_acc = 0;
      res_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
         exp = ref_sub16(a, b, bin);
         op_a = a; op_b = b; borrow_in = bin; start_valid = 1'b1;
         n = 0;
         while (!start_ready && n < 20) begin @(posedge clk); #1; t++; n++; end
         @(posedge clk); #1; t++;
         if (k > 0) begin
            checks++;
            if (t - prev_acc !== 7) begin errors++; $display("FAIL b2b_period k=%0d got=%0d exp=7", k, t - prev_acc); end
         end
         prev_acc = t;
         n = 0;
         while (!res_valid && n < 20) begin @(posedge clk); #1; t++; n++; end
         checks++;
         if ({res_valid, result, borrow_out} !== {1'b1, exp[15:0], exp[16]}) begin
            errors++;
            $display("FAIL b2b_result k=%0d got v=%b r=%h bo=%b exp v=1 r=%h bo=%b", k, res_valid, result, borrow_out, exp[15:0], exp[16]);
         end
      end
      start_valid = 1'b0;
      @(posedge clk); #1;
      res_ready = 1'b0;
      checks++; if ({start_ready, res_valid} !== 2'b10) begin errors++; $display("FAIL b2b_idle got rdy=%b v=%b exp rdy=1 v=0", start_ready, res_valid); end
   endtask

   task automatic test_nibbles1();
      logic [3:0] a, b; logic bin; logic [4:0] exp; int lat;
      for (int k = 0; k < 8; k++) begin
         if (k == 0) begin a = 4'h3; b = 4'h5; bin = 1'b0; end
         else begin a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom); end
         exp = ref_sub4(a, b, bin);
         op_a1 = a; op_b1 = b; borrow_in1 = bin; start_valid1 = 1'b1;
         lat = 0;
         while (!start_ready1 && lat < 20) begin @(posedge clk); #1; lat++; end
         @(posedge clk); #1;
         start_valid1 = 1'b0; op_a1 = 4'($urandom); op_b1 = 4'($urandom);
         lat = 0;
         do begin @(posedge clk); #1; lat++; end while (!res_valid1 && lat < 20);
         if (k == 0) begin
            checks++;
            if ({result1, borrow_out1, zero1} !== {4'hE, 1'b1, 1'b0}) begin errors++; $display("FAIL n1_dir got=%h/%b/%b exp=e/1/0", result1, borrow_out1, zero1); end
         end
         checks++;
         if ({res_valid1, result1, borrow_out1, zero1, lat} !== {1'b1, exp[3:0], exp[4], exp[3:0] == 4'h0, 32'd2}) begin
            errors++;
            $display("FAIL n1_op k=%0d a=%h b=%h bin=%b got v=%b r=%h bo=%b z=%b lat=%0d exp r=%h bo=%b lat=2", k, a, b, bin, res_valid1, result1, borrow_out1, zero1, lat, exp[3:0], exp[4]);
         end
         res_ready1 = 1'b1;
         @(posedge clk); #1;
         res_ready1 = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_back_to_back();
      test_nibbles1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete within 500us");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_nibble_serial_sub_seq
